// File: rtl/countdown_decrementer_4bit.sv
// Loadable countdown counter on a ripple half-subtractor decrementer; outputs update on the edge sampling load/en.
// No backpressure: load wins over en, and en=0 holds the count.

module half_subtractor (
  input  logic a,
  input  logic b,
  output logic diff,
  output logic borrow
);
  assign diff   = a ^ b;
  assign borrow = ~a & b;
endmodule

module countdown_decrementer_4bit #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [WIDTH-1:0] d,
  input  logic             en,
  output logic [WIDTH-1:0] q,
  output logic             zero,
  output logic             busy,
  output logic             done,
  output logic             bout
);

  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] q_nxt;
  logic             done_nxt, bout_nxt;
  logic [WIDTH-1:0] q_m1;
  logic [WIDTH:0]   brw;

  // Borrow chain seeded with the constant 1 being subtracted
  assign brw[0] = 1'b1;

  for (genvar i = 0; i < WIDTH; i++) begin : g_dec
    half_subtractor u_hs (
      .a      (q[i]),
      .b      (brw[i]),
      .diff   (q_m1[i]),
      .borrow (brw[i+1])
    );
  end

  always_comb begin
    q_nxt     = q;
    state_nxt = state;
    done_nxt  = 1'b0;
    bout_nxt  = 1'b0;
    if (load) begin
      q_nxt     = d;
      state_nxt = (d != '0) ? RUN : IDLE;
      done_nxt  = (d == '0);
    end else if (en) begin
      q_nxt = q_m1;
      if (state == IDLE) begin
        bout_nxt = brw[WIDTH];
      end else if (q == WIDTH'(1)) begin
        // Last decrement of a loaded count lands on zero this edge
        state_nxt = IDLE;
        done_nxt  = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q     <= '0;
      state <= IDLE;
      done  <= 1'b0;
      bout  <= 1'b0;
    end else begin
      q     <= q_nxt;
      state <= state_nxt;
      done  <= done_nxt;
      bout  <= bout_nxt;
    end
  end

  assign busy = (state == RUN);
  assign zero = (q == '0);

endmodule

// File: tb/tb_countdown_decrementer_4bit.sv
// Directed bench for countdown_decrementer_4bit; outputs sampled 1ns after the rising edge.
module tb_countdown_decrementer_4bit;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       load;
  logic [3:0] d;
  logic       en;
  logic [3:0] q;
  logic       zero, busy, done, bout;

  int n_cmp = 0;
  int n_err = 0;

  countdown_decrementer_4bit #(.WIDTH(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .load  (load),
    .d     (d),
    .en    (en),
    .q     (q),
    .zero  (zero),
    .busy  (busy),
    .done  (done),
    .bout  (bout)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst_n = 1'b0; load = 1'b0; en = 1'b0; d = 4'h0;
    #2;
    n_cmp++;
    if ({q, busy, done, bout, zero} !== 8'b0000_0001) begin
      n_err++;
      $display("FAIL reset_init: got q=%h busy=%b done=%b bout=%b zero=%b, need q=0 busy=0 done=0 bout=0 zero=1",
               q, busy, done, bout, zero);
    end
    tick; tick;
    rst_n = 1'b1;
    tick;
    n_cmp++;
    if ({q, busy, done, bout, zero} !== 8'b0000_0001) begin
      n_err++;
      $display("FAIL reset_release: got q=%h busy=%b done=%b bout=%b zero=%b, need q=0 busy=0 done=0 bout=0 zero=1",
               q, busy, done, bout, zero);
    end
  endtask

  task automatic test_reset_mid_run;
    load = 1'b1; d = 4'h7; en = 1'b0;
    tick;
    load = 1'b0;
    n_cmp++;
    if (q !== 4'h7 || busy !== 1'b1) begin
      n_err++;
      $display("FAIL midrst_setup: got q=%h busy=%b, need q=7 busy=1", q, busy);
    end
    #3;
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({q, busy, done, bout, zero} !== 8'b0000_0001) begin
      n_err++;
      $display("FAIL midrst_immediate: got q=%h busy=%b done=%b bout=%b zero=%b, need q=0 busy=0 done=0 bout=0 zero=1",
               q, busy, done, bout, zero);
    end
    load = 1'b1; d = 4'h5; en = 1'b1;
    for (int i = 0; i < 2; i++) begin
      tick;
      n_cmp++;
      if ({q, busy, done, bout, zero} !== 8'b0000_0001) begin
        n_err++;
        $display("FAIL midrst_hold%0d: got q=%h busy=%b done=%b bout=%b zero=%b, need q=0 busy=0 done=0 bout=0 zero=1",
                 i, q, busy, done, bout, zero);
      end
    end
    rst_n = 1'b1; load = 1'b0; en = 1'b0; d = 4'h0;
    tick;
    n_cmp++;
    if ({q, busy, done, bout, zero} !== 8'b0000_0001) begin
      n_err++;
      $display("FAIL midrst_after: got q=%h busy=%b done=%b bout=%b zero=%b, need q=0 busy=0 done=0 bout=0 zero=1",
               q, busy, done, bout, zero);
    end
  endtask

  task automatic test_full_countdown;
    logic [3:0] exp_q [6];
    logic       exp_b [6];
    logic       exp_d [6];
    exp_q = '{4'h5, 4'h4, 4'h3, 4'h2, 4'h1, 4'h0};
    exp_b = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    exp_d = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    for (int i = 0; i < 6; i++) begin
      load = (i == 0); d = 4'h5; en = (i != 0);
      tick;
      n_cmp++;
      if (q !== exp_q[i] || busy !== exp_b[i] || done !== exp_d[i] || bout !== 1'b0 || zero !== (exp_q[i] == 4'h0)) begin
        n_err++;
        $display("FAIL full_step%0d: got q=%h busy=%b done=%b bout=%b zero=%b, need q=%h busy=%b done=%b bout=0 zero=%b",
                 i, q, busy, done, bout, zero, exp_q[i], exp_b[i], exp_d[i], exp_q[i] == 4'h0);
      end
    end
    load = 1'b0; en = 1'b0;
    tick;
    n_cmp++;
    if (q !== 4'h0 || busy !== 1'b0 || done !== 1'b0) begin
      n_err++;
      $display("FAIL full_after: got q=%h busy=%b done=%b, need q=0 busy=0 done=0", q, busy, done);
    end
  endtask

  task automatic test_stalled_count;
    logic       ld_v  [6];
    logic       en_v  [6];
    logic [3:0] exp_q [6];
    logic       exp_b [6];
    ld_v  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    en_v  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
    exp_q = '{4'h3, 4'h2, 4'h2, 4'h2, 4'h1, 4'h0};
    exp_b = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    for (int i = 0; i < 6; i++) begin
      load = ld_v[i]; d = 4'h3; en = en_v[i];
      tick;
      n_cmp++;
      if (q !== exp_q[i] || busy !== exp_b[i] || done !== (i == 5) || bout !== 1'b0) begin
        n_err++;
        $display("FAIL stall_step%0d: got q=%h busy=%b done=%b bout=%b, need q=%h busy=%b done=%b bout=0",
                 i, q, busy, done, bout, exp_q[i], exp_b[i], i == 5);
      end
    end
    load = 1'b0; en = 1'b0;
  endtask

  task automatic test_zero_load;
    load = 1'b1; d = 4'h0; en = 1'b1;
    tick;
    n_cmp++;
    if (q !== 4'h0 || busy !== 1'b0 || done !== 1'b1 || bout !== 1'b0) begin
      n_err++;
      $display("FAIL zero_load: got q=%h busy=%b done=%b bout=%b, need q=0 busy=0 done=1 bout=0", q, busy, done, bout);
    end
    load = 1'b0; en = 1'b0;
    tick;
    n_cmp++;
    if (q !== 4'h0 || busy !== 1'b0 || done !== 1'b0) begin
      n_err++;
      $display("FAIL zero_load_after: got q=%h busy=%b done=%b, need q=0 busy=0 done=0", q, busy, done);
    end
  endtask

  task automatic test_reload_priority;
    logic [3:0] exp_q [3];
    exp_q = '{4'h8, 4'h7, 4'h6};
    load = 1'b1; d = 4'h9; en = 1'b0;
    tick;
    n_cmp++;
    if (q !== 4'h9 || busy !== 1'b1) begin
      n_err++;
      $display("FAIL reload_load9: got q=%h busy=%b, need q=9 busy=1", q, busy);
    end
    load = 1'b0; en = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick;
      n_cmp++;
      if (q !== exp_q[i] || busy !== 1'b1 || done !== 1'b0) begin
        n_err++;
        $display("FAIL reload_run%0d: got q=%h busy=%b done=%b, need q=%h busy=1 done=0", i, q, busy, done, exp_q[i]);
      end
    end
    load = 1'b1; d = 4'h2; en = 1'b1;
    tick;
    n_cmp++;
    if (q !== 4'h2 || busy !== 1'b1 || done !== 1'b0) begin
      n_err++;
      $display("FAIL reload_prio: got q=%h busy=%b done=%b, need q=2 busy=1 done=0", q, busy, done);
    end
    load = 1'b0;
    tick;
    n_cmp++;
    if (q !== 4'h1 || busy !== 1'b1 || done !== 1'b0) begin
      n_err++;
      $display("FAIL reload_q1: got q=%h busy=%b done=%b, need q=1 busy=1 done=0", q, busy, done);
    end
    tick;
    n_cmp++;
    if (q !== 4'h0 || busy !== 1'b0 || done !== 1'b1) begin
      n_err++;
      $display("FAIL reload_q0: got q=%h busy=%b done=%b, need q=0 busy=0 done=1", q, busy, done);
    end
    en = 1'b0;
    tick;
    n_cmp++;
    if (done !== 1'b0 || q !== 4'h0) begin
      n_err++;
      $display("FAIL reload_after: got q=%h done=%b, need q=0 done=0", q, done);
    end
  endtask

  // Starts from IDLE q=0: step i visits q=(16-i)%16 and must land on 15-i
  task automatic test_exhaustive_datapath;
    logic [3:0] exp;
    for (int i = 0; i < 16; i++) begin
      exp = 4'(15 - i);
      load = 1'b0; en = 1'b1;
      tick;
      n_cmp++;
      if (q !== exp || bout !== (i == 0) || done !== 1'b0 || busy !== 1'b0) begin
        n_err++;
        $display("FAIL dp_step%0d: got q=%h bout=%b done=%b busy=%b, need q=%h bout=%b done=0 busy=0",
                 i, q, bout, done, busy, exp, i == 0);
      end
    end
    en = 1'b0;
  endtask

  task automatic test_wrap_idle;
    logic [3:0] exp_q [3];
    logic       exp_w [3];
    exp_q = '{4'h0, 4'hF, 4'hE};
    exp_w = '{1'b0, 1'b1, 1'b0};
    en = 1'b1;
    for (int i = 0; i < 15; i++) tick;
    n_cmp++;
    if (q !== 4'h1 || busy !== 1'b0 || bout !== 1'b0) begin
      n_err++;
      $display("FAIL wrap_setup: got q=%h busy=%b bout=%b, need q=1 busy=0 bout=0", q, busy, bout);
    end
    for (int i = 0; i < 3; i++) begin
      tick;
      n_cmp++;
      if (q !== exp_q[i] || bout !== exp_w[i] || done !== 1'b0) begin
        n_err++;
        $display("FAIL wrap_step%0d: got q=%h bout=%b done=%b, need q=%h bout=%b done=0",
                 i, q, bout, done, exp_q[i], exp_w[i]);
      end
    end
    en = 1'b0;
    tick;
    n_cmp++;
    if (q !== 4'hE || bout !== 1'b0) begin
      n_err++;
      $display("FAIL wrap_hold: got q=%h bout=%b, need q=e bout=0", q, bout);
    end
  endtask

  initial begin
    test_reset;
    test_reset_mid_run;
    test_full_countdown;
    test_stalled_count;
    test_zero_load;
    test_reload_priority;
    test_exhaustive_datapath;
    test_wrap_idle;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
